// File: rtl/expmul_dispatch_pkg.sv
// Shared types and constants for the expmul initiator: Q4.4 operand type,
// row length, "no max yet" sentinel and the dispatcher state encoding.
`ifndef MAX_SEQ_LENGTH
`define MAX_SEQ_LENGTH 64
`endif

package expmul_dispatch_pkg;
  localparam int SEQ_LEN = `MAX_SEQ_LENGTH;
  localparam int SCORE_W = 8;

  typedef logic signed [SCORE_W-1:0] EXPMUL_DIFF_IN_QT;
  typedef logic [$clog2(`MAX_SEQ_LENGTH)-1:0] KV_IDX_T;

  localparam EXPMUL_DIFF_IN_QT NEG_INF = 8'sh80;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;
endpackage

// File: rtl/expmul_dispatch_req_slot.sv
// One expmul request channel: a valid flag set on load and cleared by the
// downstream handshake, plus this-cycle completion and still-pending flags.
module expmul_req_slot (
  input  logic clk,
  input  logic rst,
  input  logic load,
  input  logic rdy,
  output logic vld,
  output logic pending,
  output logic done
);
  logic vld_reg;

  // A load in the same cycle as the handshake wins: the next request follows back-to-back.
  always_ff @(posedge clk) begin
    if (rst)
      vld_reg <= 1'b0;
    else if (load)
      vld_reg <= 1'b1;
    else if (vld_reg && rdy)
      vld_reg <= 1'b0;
  end

  assign vld     = vld_reg;
  assign done    = vld_reg && rdy;
  assign pending = vld_reg && !rdy;
endmodule

// File: rtl/expmul_dispatch.sv
// Score-side initiator of the expmul interface: tracks the running row max and
// issues paired O-rescale / V-weight requests, one score per cycle when unstalled.
module expmul_dispatch
  import expmul_dispatch_pkg::*;
#(
  parameter int SEQ_LEN = expmul_dispatch_pkg::SEQ_LEN
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       score_vld,
  output logic                       score_rdy,
  input  logic [SCORE_W-1:0]         score,
  output logic                       o_vld,
  input  logic                       o_rdy,
  output logic [SCORE_W-1:0]         o_a,
  output logic [SCORE_W-1:0]         o_b,
  output logic                       v_vld,
  input  logic                       v_rdy,
  output logic [SCORE_W-1:0]         v_a,
  output logic [SCORE_W-1:0]         v_b,
  output logic                       row_first,
  output logic                       row_last,
  output logic [$clog2(SEQ_LEN)-1:0] kv_idx
);
  localparam int CNT_W = $clog2(SEQ_LEN);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SEQ_LEN - 1);

  state_t            state_reg, state_next;
  logic [CNT_W-1:0]  cnt_reg;
  EXPMUL_DIFF_IN_QT  m_reg, s, m_new;
  logic              accept, all_clear;
  logic              o_pending, o_done, v_pending, v_done;

  assign s      = score;
  assign accept = score_vld && score_rdy;

  expmul_req_slot u_o_slot (
    .clk(clk), .rst(rst), .load(accept), .rdy(o_rdy),
    .vld(o_vld), .pending(o_pending), .done(o_done)
  );

  expmul_req_slot u_v_slot (
    .clk(clk), .rst(rst), .load(accept), .rdy(v_rdy),
    .vld(v_vld), .pending(v_pending), .done(v_done)
  );

  // Key 0 ignores the stored max, so a NEG_INF score needs no special case.
  always_comb begin
    m_new = s;
    if (cnt_reg != '0 && m_reg > s)
      m_new = m_reg;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = IDLE;
    if (accept || o_pending || v_pending)
      state_next = BUSY;
  end

  always_comb begin
    all_clear = (!o_vld || o_done) && (!v_vld || v_done);
    score_rdy = (state_reg == IDLE) || all_clear;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg   <= '0;
      m_reg     <= NEG_INF;
      o_a       <= '0;
      o_b       <= '0;
      v_a       <= '0;
      v_b       <= '0;
      row_first <= 1'b0;
      row_last  <= 1'b0;
      kv_idx    <= '0;
    end else if (accept) begin
      o_a       <= (cnt_reg == '0) ? m_new : m_reg;
      o_b       <= m_new;
      v_a       <= s;
      v_b       <= m_new;
      kv_idx    <= cnt_reg;
      row_first <= (cnt_reg == '0);
      row_last  <= (cnt_reg == CNT_LAST);
      if (cnt_reg == CNT_LAST) begin
        cnt_reg <= '0;
        m_reg   <= NEG_INF;
      end else begin
        cnt_reg <= cnt_reg + 1'b1;
        m_reg   <= m_new;
      end
    end
  end
endmodule
